// File: rtl/dut_clk_freq_checker.sv
// Frequency checker for the board-under-test divided clock on pin16_sck.
// Measures rise-to-rise periods in clk_48mhz cycles and reports PASS/FAIL.
//
// Ports:
//   clk_48mhz   in   jig clock, single clock domain
//   reset       in   synchronous, active-high
//   start       in   one-cycle request to begin a check (ignored while busy)
//   dut_clk     in   asynchronous divided clock from the board under test
//   busy        out  check in progress (ARM or MEASURE)
//   done        out  result available (PASS or FAIL), held until next start
//   pass        out  result is PASS
//   fail_code   out  00 none, 01 timeout, 10 period too short, 11 too long
//   last_period out  most recent measured period, 0 until first measurement
module dut_clk_freq_checker #(
    parameter int unsigned CNT_W         = 23,
    parameter int unsigned EXPECTED      = 2000002,
    parameter int unsigned TOLERANCE     = 20000,
    parameter int unsigned REQUIRED_GOOD = 4,
    parameter int unsigned TIMEOUT       = 4000000
) (
    input  logic             clk_48mhz,
    input  logic             reset,
    input  logic             start,
    input  logic             dut_clk,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] last_period
);

    localparam int unsigned GW = (REQUIRED_GOOD > 1) ? $clog2(REQUIRED_GOOD + 1) : 1;

    localparam logic [CNT_W:0]   LO_C    = (CNT_W+1)'(EXPECTED - TOLERANCE);
    localparam logic [CNT_W:0]   HI_C    = (CNT_W+1)'(EXPECTED + TOLERANCE);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W:0]   ONE_W   = (CNT_W+1)'(1);
    localparam logic [GW-1:0]    REQ_C   = GW'(REQUIRED_GOOD);
    localparam logic [GW-1:0]    GONE_C  = GW'(1);

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_SHORT   = 2'b10;
    localparam logic [1:0] FC_LONG    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE,
        S_PASS,
        S_FAIL
    } state_e;

    state_e           state_q;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q;
    logic [GW-1:0]    good_q;
    logic             busy_q, done_q, pass_q;
    logic [1:0]       fail_code_q;
    logic [CNT_W-1:0] last_period_q;

    logic             rise_d;
    logic             timeout_d;
    logic [CNT_W:0]   period_d;
    logic [GW-1:0]    good_d;

    // One extra bit on the period so cnt+1 can never wrap before the range check.
    assign rise_d    = s2_q & ~s3_q;
    assign period_d  = {1'b0, cnt_q} + ONE_W;
    assign timeout_d = (cnt_q == TO_LAST) & ~rise_d;
    assign good_d    = good_q + GONE_C;

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q       <= S_IDLE;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            cnt_q         <= '0;
            good_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_code_q   <= FC_NONE;
            last_period_q <= '0;
        end else begin
            s1_q <= dut_clk;
            s2_q <= s1_q;
            s3_q <= s2_q;
            unique case (state_q)
                S_IDLE, S_PASS, S_FAIL: begin
                    if (start) begin
                        state_q       <= S_ARM;
                        cnt_q         <= '0;
                        good_q        <= '0;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        pass_q        <= 1'b0;
                        fail_code_q   <= FC_NONE;
                        last_period_q <= '0;
                    end
                end
                S_ARM: begin
                    // First rise only aligns the phase; nothing is measured yet.
                    if (rise_d) begin
                        state_q <= S_MEASURE;
                        cnt_q   <= '0;
                    end else if (timeout_d) begin
                        state_q     <= S_FAIL;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        fail_code_q <= FC_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + ONE_C;
                    end
                end
                S_MEASURE: begin
                    // A rise on the timeout cycle wins and is range checked.
                    if (rise_d) begin
                        cnt_q         <= '0;
                        last_period_q <= period_d[CNT_W-1:0];
                        if (period_d < LO_C) begin
                            state_q     <= S_FAIL;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            fail_code_q <= FC_SHORT;
                        end else if (period_d > HI_C) begin
                            state_q     <= S_FAIL;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            fail_code_q <= FC_LONG;
                        end else if (good_d == REQ_C) begin
                            state_q <= S_PASS;
                            good_q  <= good_d;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else begin
                            good_q <= good_d;
                        end
                    end else if (timeout_d) begin
                        state_q     <= S_FAIL;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        fail_code_q <= FC_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + ONE_C;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_code   = fail_code_q;
    assign last_period = last_period_q;

endmodule

// File: tb/tb_dut_clk_freq_checker.sv
// Self-checking bench for dut_clk_freq_checker.
// Directed cases plus randomized period sequences against a period-list model.
module tb_dut_clk_freq_checker;

    localparam int CNT_W     = 8;
    localparam int EXPECTED  = 100;
    localparam int TOLERANCE = 2;
    localparam int REQ       = 3;
    localparam int TIMEOUT   = 200;
    localparam int LO        = EXPECTED - TOLERANCE;
    localparam int HI        = EXPECTED + TOLERANCE;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             dut_clk;
    logic             busy;
    logic             done;
    logic             pass;
    logic [1:0]       fail_code;
    logic [CNT_W-1:0] last_period;

    always #5 clk = ~clk;

    dut_clk_freq_checker #(
        .CNT_W        (CNT_W),
        .EXPECTED     (EXPECTED),
        .TOLERANCE    (TOLERANCE),
        .REQUIRED_GOOD(REQ),
        .TIMEOUT      (TIMEOUT)
    ) u_dut (
        .clk_48mhz  (clk),
        .reset      (reset),
        .start      (start),
        .dut_clk    (dut_clk),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_code  (fail_code),
        .last_period(last_period)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          gaps[$];
    int          first_gap;
    int          start_at;
    int          reset_at;
    int          done_at;
    logic        done_after_start;
    logic        busy_mid;
    logic [31:0] snap;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outcome of a check from the list of dut_clk rise-to-rise gaps.
    // first_gap <= 0 means dut_clk never rises.
    function automatic void model(output logic ep, output logic [1:0] ec,
                                  output int el);
        int good;
        good = 0;
        ep   = 1'b0;
        ec   = 2'b01;
        el   = 0;
        if (first_gap <= 0) return;
        foreach (gaps[i]) begin
            if (gaps[i] > TIMEOUT) return;
            el = gaps[i];
            if (gaps[i] < LO) begin
                ec = 2'b10;
                return;
            end
            if (gaps[i] > HI) begin
                ec = 2'b11;
                return;
            end
            good++;
            if (good == REQ) begin
                ep = 1'b1;
                ec = 2'b00;
                return;
            end
        end
    endfunction

    // Pulse start, then play dut_clk rises at first_gap, first_gap+gaps[0], ...
    // Cycle k counts clock edges after the edge that accepted start.
    task automatic run_check();
        int rises[$];
        int t;
        int budget;
        int hi;
        rises = {};
        t = 0;
        if (first_gap > 0) begin
            t = first_gap;
            rises.push_back(t);
            foreach (gaps[i]) begin
                t += gaps[i];
                rises.push_back(t);
            end
        end
        budget   = t + TIMEOUT + 20;
        done_at  = -1;
        busy_mid = 1'b0;
        snap     = '1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_after_start = done;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            hi = 0;
            foreach (rises[j]) begin
                if (k >= rises[j] && k < rises[j] + 5) hi = 1;
            end
            dut_clk = (hi != 0);
            start   = (k == start_at);
            reset   = (k == reset_at);
            @(posedge clk);
            #1;
            if (k == 50) busy_mid = busy;
            if (k == reset_at) begin
                snap = {19'd0, busy, done, pass, fail_code, last_period};
                break;
            end
            if (done) begin
                done_at = k;
                break;
            end
        end
        start   = 1'b0;
        reset   = 1'b0;
        dut_clk = 1'b0;
    endtask

    task automatic check_outcome(input string tag);
        logic       ep;
        logic [1:0] ec;
        int         el;
        model(ep, ec, el);
        chk({tag, ".done_seen"}, 32'(done_at > 0), 32'd1);
        chk({tag, ".pass"}, 32'(pass), 32'(ep));
        chk({tag, ".fail_code"}, 32'(fail_code), 32'(ec));
        chk({tag, ".last_period"}, 32'(last_period), 32'(el));
        chk({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        int g;
        reset    = 1'b1;
        start    = 1'b0;
        dut_clk  = 1'b0;
        start_at = -1;
        reset_at = -1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.pass", 32'(pass), 32'd0);
        chk("rst.fail_code", 32'(fail_code), 32'd0);
        chk("rst.last_period", 32'(last_period), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Nominal period: done after the 4th rise (rise at cycle 305 + sync delay).
        first_gap = 5;
        gaps = {100, 100, 100};
        run_check();
        check_outcome("nominal");
        chk("nominal.busy_mid", 32'(busy_mid), 32'd1);
        chk("nominal.latency", 32'(done_at >= 307 && done_at <= 308), 32'd1);

        gaps = {97};
        run_check();
        check_outcome("short97");

        gaps = {98, 102, 98};
        run_check();
        check_outcome("edges");

        gaps = {103};
        run_check();
        check_outcome("long103");

        gaps = {100, 200};
        run_check();
        check_outcome("rise_at_timeout");

        gaps = {100, 201};
        run_check();
        check_outcome("timeout_measure");

        // dut_clk static: timeout exactly TIMEOUT cycles after start accepted.
        first_gap = 0;
        gaps = {};
        run_check();
        check_outcome("static");
        chk("static.done_at", 32'(done_at), 32'(TIMEOUT));

        // Reset in MEASURE clears every output on the next cycle.
        first_gap = 5;
        gaps = {100, 100, 100};
        reset_at = 150;
        run_check();
        chk("midreset.outputs", snap, 32'd0);
        reset_at = -1;
        run_check();
        check_outcome("after_reset");

        // start during MEASURE is ignored.
        start_at = 150;
        run_check();
        check_outcome("start_in_measure");
        chk("start_in_measure.latency",
            32'(done_at >= 307 && done_at <= 308), 32'd1);
        start_at = -1;

        // start from PASS drops done and reruns.
        run_check();
        chk("rerun.done_drop", 32'(done_after_start), 32'd0);
        check_outcome("rerun");

        for (int it = 0; it < 25; it++) begin
            gaps = {};
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 9);
                if (r < 7) g = $urandom_range(LO, HI);
                else if (r < 9) g = $urandom_range(90, 110);
                else g = $urandom_range(195, 205);
                gaps.push_back(g);
            end
            first_gap = $urandom_range(1, 20);
            run_check();
            check_outcome($sformatf("rand%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
